// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO read-side controller feeding a 2-entry skid buffer
// Issues credit-limited reads, buffers returning words and counts delivered words.
module fifo_reader #(
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          EN,
  output logic          RD,
  input  logic [DW-1:0] FIFO_DOUT,
  input  logic          FIFO_EMPTY,
  input  logic          FIFO_VALID,
  input  logic          FIFO_UNDER,
  output logic [DW-1:0] OUT_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [CW-1:0] WORD_CNT,
  output logic          ERR
);

  logic [1:0]    r_occ;
  logic          r_inflight;
  logic          r_run;
  logic          r_err;
  logic [DW-1:0] r_buf0;
  logic [DW-1:0] r_buf1;
  logic [CW-1:0] r_word_cnt;

  logic          w_pop;
  logic          w_drop;
  logic [1:0]    w_credit;

  assign w_pop    = (r_occ != 2'd0) && OUT_READY;
  // A pop implies r_occ >= 1, so this never underflows.
  assign w_credit = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
  // r_run holds off reads until the first edge after reset release.
  assign RD       = RST_N && r_run && EN && !FIFO_EMPTY && (w_credit < 2'd2);
  assign w_drop   = FIFO_VALID && (r_occ == 2'd2) && !w_pop;

  assign OUT_DATA  = r_buf0;
  assign OUT_VALID = (r_occ != 2'd0);
  assign WORD_CNT  = r_word_cnt;
  assign ERR       = r_err;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_run      <= 1'b0;
      r_err      <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_word_cnt <= '0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= RD;
      if (w_pop)
        r_word_cnt <= r_word_cnt + {{(CW-1){1'b0}}, 1'b1};
      if (FIFO_UNDER || (r_inflight != FIFO_VALID) || w_drop)
        r_err <= 1'b1;
      case ({FIFO_VALID, w_pop})
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= FIFO_DOUT;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= FIFO_DOUT;
          end
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0 <= FIFO_DOUT;
            r_occ  <= 2'd1;
          end else if (r_occ == 2'd1) begin
            r_buf1 <= FIFO_DOUT;
            r_occ  <= 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - scoreboard bench for fifo_reader with a behavioural upstream FIFO
module tb_fifo_reader;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic          EN = 1'b0;
  logic          RD;
  logic [DW-1:0] FIFO_DOUT = '0;
  logic          FIFO_EMPTY = 1'b1;
  logic          FIFO_VALID = 1'b0;
  logic          FIFO_UNDER = 1'b0;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [CW-1:0] WORD_CNT;
  logic          ERR;

  fifo_reader #(.DW(DW), .CW(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .RD(RD),
    .FIFO_DOUT(FIFO_DOUT), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_VALID(FIFO_VALID),
    .FIFO_UNDER(FIFO_UNDER), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .WORD_CNT(WORD_CNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int  cyc = 0;
  int  rd_cnt = 0;
  int  first_rd = -1;
  int  first_ov = -1;
  int  first_pop = -1;
  int  last_pop = -1;
  int  exp_cnt = 0;
  logic err_exp = 1'b0;
  logic rd_s = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Upstream FIFO: registered empty flag, read data valid one cycle after RD.
  always begin
    @(negedge CLK);
    rd_s = RD;
    @(posedge CLK);
    #1;
    FIFO_VALID = 1'b0;
    if (rd_s && fifo_q.size() > 0) begin
      FIFO_DOUT  = fifo_q.pop_front();
      FIFO_VALID = 1'b1;
    end
    FIFO_EMPTY = (fifo_q.size() == 0);
  end

  always @(negedge CLK) begin
    cyc++;
    if (RST_N) begin
      chk("rd_while_empty", {31'b0, RD && FIFO_EMPTY}, 32'd0);
      if (RD) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (OUT_VALID && first_ov < 0) first_ov = cyc;
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pop", 32'd1, 32'd0);
        end else begin
          chk("out_data", {16'b0, OUT_DATA}, {16'b0, exp_q.pop_front()});
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        exp_cnt  = (exp_cnt + 1) % 16;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + DW'(i));
      exp_q.push_back(base + DW'(i));
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (fifo_q.size() == 0 && exp_q.size() == 0) break;
    end
    chk(tag, exp_q.size(), 32'd0);
    chk({tag, "_wcnt"}, {28'b0, WORD_CNT}, exp_cnt);
    chk({tag, "_err"}, {31'b0, ERR}, {31'b0, err_exp});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1 RST_N = 1'b0;
    #1;
    chk("rst_rd", {31'b0, RD}, 32'd0);
    chk("rst_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("rst_wcnt", {28'b0, WORD_CNT}, 32'd0);
    chk("rst_err", {31'b0, ERR}, 32'd0);
    chk("rst_data", {16'b0, OUT_DATA}, 32'd0);
    step(3);
    RST_N = 1'b1;
    step(2);

    // Streaming
    EN = 1'b1;
    OUT_READY = 1'b1;
    first_rd = -1; first_ov = -1; first_pop = -1; last_pop = -1;
    load(8, 16'h0001);
    drain("stream");
    chk("stream_lat", first_ov - first_rd, 32'd2);
    chk("stream_b2b", last_pop - first_pop, 32'd7);
    chk("stream_cnt8", {28'b0, WORD_CNT}, 32'd8);

    // Backpressure
    OUT_READY = 1'b0;
    step(1);
    rd_cnt = 0;
    load(5, 16'h0100);
    step(10);
    chk("bp_rd_pulses", rd_cnt, 32'd2);
    chk("bp_valid", {31'b0, OUT_VALID}, 32'd1);
    chk("bp_head", {16'b0, OUT_DATA}, 32'h0100);
    OUT_READY = 1'b1;
    drain("bp");

    // Single-word empty boundary
    rd_cnt = 0;
    load(1, 16'h0200);
    step(8);
    chk("empty_rd_pulses", rd_cnt, 32'd1);
    chk("empty_flag", {31'b0, FIFO_EMPTY}, 32'd1);
    drain("empty");

    // EN toggle mid-stream
    load(8, 16'h0300);
    step(3);
    EN = 1'b0;
    rd_cnt = 0;
    step(4);
    chk("en_off_rd", rd_cnt, 32'd0);
    EN = 1'b1;
    drain("en");

    // Reset with a full skid buffer
    OUT_READY = 1'b0;
    load(4, 16'h0400);
    step(6);
    chk("pre_rst_valid", {31'b0, OUT_VALID}, 32'd1);
    RST_N = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    exp_cnt = 0;
    err_exp = 1'b0;
    #1;
    chk("async_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("async_wcnt", {28'b0, WORD_CNT}, 32'd0);
    chk("async_rd", {31'b0, RD}, 32'd0);
    load(17, 16'h0500);
    step(2);
    OUT_READY = 1'b1;
    RST_N = 1'b1;
    #1;
    chk("rd_before_edge", {31'b0, RD}, 32'd0);
    drain("post_rst");
    chk("wcnt_wrap", {28'b0, WORD_CNT}, 32'd1);

    // Underflow makes ERR sticky
    FIFO_UNDER = 1'b1;
    err_exp = 1'b1;
    step(1);
    FIFO_UNDER = 1'b0;
    step(1);
    chk("err_set", {31'b0, ERR}, 32'd1);
    step(3);
    chk("err_sticky", {31'b0, ERR}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DW, default 16, FIFO and output data width in bits.
REQ-002 SHALL have parameter CW, default 16, width of the delivered-word counter.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port EN  input  1  read enable; 0 = no new FIFO reads issued.
REQ-006 SHALL have port RD  output  1  read strobe to upstream FIFO, one word per asserted cycle.
REQ-007 SHALL have port FIFO_DOUT  input  DW  FIFO read data, valid when FIFO_VALID=1.
REQ-008 SHALL have port FIFO_EMPTY  input  1  FIFO empty flag, registered in FIFO.
REQ-009 SHALL have port FIFO_VALID  input  1  FIFO read-data valid, one cycle after an accepted RD.
REQ-010 SHALL have port FIFO_UNDER  input  1  FIFO underflow pulse.
REQ-011 SHALL have port OUT_DATA  output  DW  downstream data, head of skid buffer.
REQ-012 SHALL have port OUT_VALID  output  1  downstream data valid.
REQ-013 SHALL have port OUT_READY  input  1  downstream accepts when OUT_VALID and OUT_READY both 1.
REQ-014 SHALL have port WORD_CNT  output  CW  count of words delivered downstream, wraps modulo 2^CW.
REQ-015 SHALL have port ERR  output  1  sticky error: FIFO_UNDER seen, or missing/unexpected FIFO_VALID.

Function
REQ-016 SHALL hold a 2-entry skid buffer (OCC 0..2) plus a 1-bit INFLIGHT register set on the cycle after RD=1.
REQ-017 SHALL drive RD combinationally = EN && !FIFO_EMPTY && (OCC + INFLIGHT + pending-pop-free) < 2, where credit counts the slot freed by a same-cycle downstream pop: RD=1 iff EN && !FIFO_EMPTY && (OCC + INFLIGHT - (OUT_VALID&&OUT_READY)) < 2.
REQ-018 SHALL never assert RD while FIFO_EMPTY=1.
REQ-019 SHALL write FIFO_DOUT into the buffer tail on FIFO_VALID=1; read latency RD-to-buffer = 2 edges, RD-to-OUT_VALID = 2 cycles when buffer was empty.
REQ-020 SHALL present the oldest entry on OUT_DATA with OUT_VALID = (OCC>0); OUT_DATA stable while OUT_VALID=1 and OUT_READY=0.
REQ-021 SHALL on simultaneous push (FIFO_VALID) and pop (OUT_VALID&&OUT_READY) keep OCC unchanged and preserve order.
REQ-022 SHALL guarantee OCC never exceeds 2; a push with OCC=2 and no pop SHALL set ERR and drop the word.
REQ-023 SHALL sustain one word per cycle throughput with OUT_READY held 1 and FIFO non-empty.
REQ-024 SHALL increment WORD_CNT by 1 on each pop, wrapping from 2^CW-1 to 0.
REQ-025 SHALL set ERR on FIFO_UNDER=1, on INFLIGHT=1 with FIFO_VALID=0, or on FIFO_VALID=1 with INFLIGHT=0; ERR clears only by reset.
REQ-026 SHALL, when EN drops, stop new RD immediately; in-flight word still captured; buffered words still delivered.

Reset
REQ-027 SHALL, on RST_N=0, asynchronously clear OCC, INFLIGHT, WORD_CNT, ERR, OUT_DATA to 0; OUT_VALID=0; RD=0 while RST_N=0.
REQ-028 SHALL discard any in-flight or buffered words on reset mid-operation; no FIFO_VALID in the first cycle after deassertion is treated as error only if INFLIGHT=1 (it is 0).
REQ-029 SHALL resume RD no earlier than the first rising edge after RST_N deasserts.

Verification
REQ-030 SHALL cover streaming: FIFO holds 8 words 0x0001..0x0008, EN=1, OUT_READY=1 -> OUT_DATA 0x0001..0x0008 on 8 consecutive cycles, first 2 cycles after first RD, WORD_CNT=8, ERR=0.
REQ-031 SHALL cover backpressure: OUT_READY=0 with FIFO holding 5 words -> exactly 2 RD pulses, OCC=2, OUT_DATA held at first word; OUT_READY=1 -> remaining words in order, no loss.
REQ-032 SHALL cover empty boundary: FIFO holds 1 word -> one RD, FIFO_EMPTY rises next cycle, no further RD, FIFO_UNDER never asserted, ERR=0.
REQ-033 SHALL cover EN toggle: EN=0 for 4 cycles mid-stream -> RD=0 those cycles, in-flight word delivered, order preserved after EN=1.
REQ-034 SHALL cover reset mid-stream: RST_N=0 with OCC=2 -> OUT_VALID=0, WORD_CNT=0 immediately (asynchronous); streaming resumes correctly after release.
REQ-035 SHALL cover error and wrap: force FIFO_UNDER=1 one cycle -> ERR=1 and stays 1; with CW=4, 17 pops -> WORD_CNT=1.
